flap_sequencer: RTL

//  Game sequencer for the LED Flappy Bird array. Generates the shared per-tick enable strobe,

---
 rtl/flap_pkg.sv | 21 ++
 rtl/flap_sequencer_key_sync_edge.sv | 27 ++
 rtl/flap_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/flap_pkg.sv
// Shared types and helpers for the LED Flappy Bird game sequencer.
package flap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_t;

  // Counter width able to hold 0..div-1; never narrower than one bit.
  function automatic int tick_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= top) ? top : value + 32'd1;
  endfunction

endpackage

// File: rtl/flap_sequencer_key_sync_edge.sv
// Two-flop synchroniser for an asynchronous key plus a one-cycle rising-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= key;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/flap_sequencer.sv
// Game sequencer: tick strobe, flap command, collision detection, score and restart pulse.
// Optional SPEEDUP_EN shortens the tick period as the score grows.
module flap_sequencer
  import flap_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int TICK_DIV = 16,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic [ROWS-1:0]    bird_rows,
  input  logic [ROWS-1:0]    pipe_rows,
  input  logic               pipe_pass,
  output logic               enable,
  output logic               up,
  output logic               gameOver,
  output logic               light_reset,
  output logic [SCORE_W-1:0] score,
  output game_t              state
);

  localparam int TICK_W = tick_w(TICK_DIV);

  logic [TICK_W-1:0] count;
  logic              key_rise;
  logic              flap_pending;
  logic              check_due;
  logic              collide;
  logic              tick_last;
  game_t             state_next;

  key_sync_edge u_key_sync (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .rise  (key_rise)
  );

`ifdef SPEEDUP_EN
  logic [TICK_W:0] period;

  // Every 8 points halves the tick, bottoming out at a quarter of TICK_DIV.
  function automatic logic [TICK_W:0] period_for(input logic [SCORE_W-1:0] pts);
    logic [SCORE_W-1:0] level;
    level = pts >> 3;
    if (level >= SCORE_W'(2))
      return (TICK_W+1)'(TICK_DIV) >> 2;
    return (TICK_W+1)'(TICK_DIV) >> level;
  endfunction

  assign tick_last = ({1'b0, count} == (period - (TICK_W+1)'(1)));
`else
  assign tick_last = (count == TICK_W'(TICK_DIV - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    enable     = 1'b0;
    gameOver   = 1'b0;
    collide    = 1'b0;
    case (state)
      IDLE: begin
        if (key_rise)
          state_next = PLAY;
      end
      PLAY: begin
        enable  = tick_last;
        collide = check_due && ((|(bird_rows & pipe_rows)) || (bird_rows == '0));
        if (collide)
          state_next = OVER;
      end
      OVER: begin
        gameOver = 1'b1;
        if (key_rise)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cells update on the enable edge, so the collision check looks one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      flap_pending <= 1'b0;
      up           <= 1'b0;
      check_due    <= 1'b0;
      score        <= '0;
      light_reset  <= 1'b0;
`ifdef SPEEDUP_EN
      period       <= (TICK_W+1)'(TICK_DIV);
`endif
    end else begin
      check_due   <= enable;
      light_reset <= (state == OVER) && key_rise;
      case (state)
        IDLE: begin
          count <= '0;
          if (key_rise) begin
            score        <= '0;
            flap_pending <= 1'b0;
            up           <= 1'b0;
`ifdef SPEEDUP_EN
            period       <= (TICK_W+1)'(TICK_DIV);
`endif
          end
        end
        PLAY: begin
          if (collide) begin
            up           <= 1'b0;
            flap_pending <= 1'b0;
          end else begin
            if (enable) begin
              count        <= '0;
              up           <= flap_pending;
              flap_pending <= key_rise;
`ifdef SPEEDUP_EN
              period       <= period_for(score);
`endif
            end else begin
              count <= count + TICK_W'(1);
              if (key_rise)
                flap_pending <= 1'b1;
            end
            if (pipe_pass)
              score <= SCORE_W'(sat_inc(32'(score), SCORE_W));
          end
        end
        OVER: begin
          if (key_rise)
            count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
